// File: rtl/mmu_sequencer.sv
// Operand sequencer for an external 2x2 systolic PE array: loads A/B, skews them onto
// the array edges, captures accumulators and streams results. Optional: SEQ_RELU_EN.
module mmu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [2:0]         load_addr,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               start,
    output logic [WIDTH-1:0]   a_row0,
    output logic [WIDTH-1:0]   a_row1,
    output logic [WIDTH-1:0]   b_col0,
    output logic [WIDTH-1:0]   b_col1,
    output logic               pe_clear,
    input  logic [WIDTH+3:0]   c00,
    input  logic [WIDTH+3:0]   c01,
    input  logic [WIDTH+3:0]   c10,
    input  logic [WIDTH+3:0]   c11,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH+3:0]   res_data,
    output logic [1:0]         res_idx,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state_o
);

    localparam int RW = WIDTH + 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       km1;

    // Operand buffer: address {B_not_A, row, col}
    logic [WIDTH-1:0] opnd_q [8];
    logic [RW-1:0]    res_q  [4];

    logic [WIDTH-1:0] a_row0_q, a_row1_q, b_col0_q, b_col1_q;
    logic [WIDTH-1:0] a_row0_d, a_row1_d, b_col0_d, b_col1_d;
    logic             pe_clear_q;

    function automatic logic [RW-1:0] capture_val(input logic [RW-1:0] v);
`ifdef SEQ_RELU_EN
        return v[RW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Handshake: a result transfers on any cycle where res_valid && res_ready; while
    // res_ready is low, res_data/res_idx hold and res_valid stays high.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                k_d     = 3'd0;
            end
            S_FEED: begin
                if (k_q == 3'd4) begin
                    state_d = S_CAPTURE;
                    k_d     = 3'd0;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_OUTPUT;
                idx_d   = 2'd0;
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Edge operands are computed from the upcoming state so the registered outputs
    // line up exactly with the FEED cycle they belong to.
    always_comb begin
        a_row0_d = '0;
        a_row1_d = '0;
        b_col0_d = '0;
        b_col1_d = '0;
        km1      = k_d - 3'd1;
        if (state_d == S_FEED) begin
            if (k_d < 3'd2) begin
                a_row0_d = opnd_q[{1'b0, 1'b0, k_d[0]}];
                b_col0_d = opnd_q[{1'b1, k_d[0], 1'b0}];
            end
            if (k_d == 3'd1 || k_d == 3'd2) begin
                a_row1_d = opnd_q[{1'b0, 1'b1, km1[0]}];
                b_col1_d = opnd_q[{1'b1, km1[0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            idx_q      <= '0;
            pe_clear_q <= 1'b0;
            a_row0_q   <= '0;
            a_row1_q   <= '0;
            b_col0_q   <= '0;
            b_col1_q   <= '0;
            for (int i = 0; i < 8; i++) opnd_q[i] <= '0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            pe_clear_q <= (state_d == S_CLEAR);
            a_row0_q   <= a_row0_d;
            a_row1_q   <= a_row1_d;
            b_col0_q   <= b_col0_d;
            b_col1_q   <= b_col1_d;
            if (state_q == S_IDLE && load_en) opnd_q[load_addr] <= load_data;
            if (state_q == S_CAPTURE) begin
                res_q[0] <= capture_val(c00);
                res_q[1] <= capture_val(c01);
                res_q[2] <= capture_val(c10);
                res_q[3] <= capture_val(c11);
            end
        end
    end

    assign a_row0      = a_row0_q;
    assign a_row1      = a_row1_q;
    assign b_col0      = b_col0_q;
    assign b_col1      = b_col1_q;
    assign pe_clear    = pe_clear_q;
    assign res_valid   = (state_q == S_OUTPUT);
    assign res_idx     = idx_q;
    assign res_data    = res_q[idx_q];
    assign busy        = (state_q != S_IDLE);
    assign done        = res_valid && res_ready && (idx_q == 2'd3);
    assign dbg_state_o = state_q;

endmodule
